// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and oversampling geometry.
// The transmitter can use the same encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

    // Tick counter spans one bit period, or a longer stop period (1.5/2 stop bits).
    function automatic int tick_width(input int sbit);
        return (sbit > OVERSAMPLE) ? $clog2(sbit) : $clog2(OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the flop value in reset (1 for an idle-high serial line).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic gclk,
    input  logic grst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled via s_tick, LSB-first data, one-PCLK done pulse.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx #(
    parameter int DBit = 8,
    parameter int SBit = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    input  logic            s_tick,
    input  logic            rx_dataIn,
`ifdef UART_RX_PARITY_EN
    input  logic            rx_parity_odd,
    output logic            rx_parity_err,
`endif
    output logic [DBit-1:0] rx_dataOut,
    output logic            rx_done_tick,
    output logic            rx_frame_err,
    output logic            rx_busy
);
    import uart_pkg::*;

    localparam int TW = tick_width(SBit);
    localparam int NW = (DBit > 1) ? $clog2(DBit) : 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(START_MID);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SBit - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBit - 1);

    uart_state_e     state;
    logic [TW-1:0]   tick;
    logic [NW-1:0]   n;
    logic [DBit-1:0] shreg;
    logic            rxs;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .gclk   (PCLK),
        .grst_n (PRESETn),
        .d      (rx_dataIn),
        .q      (rxs)
    );

    assign rx_busy = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state        <= IDLE;
            tick         <= '0;
            n            <= '0;
            shreg        <= '0;
            rx_dataOut   <= '0;
            rx_done_tick <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            if (s_tick) begin
                case (state)
                    IDLE: if (!rxs) begin
                        state <= START;
                        tick  <= '0;
                    end
                    START: if (tick == TICK_MID) begin
                        // A line back high at mid start bit is noise, not a frame.
                        if (!rxs) begin
                            state <= DATA;
                            tick  <= '0;
                            n     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                    DATA: if (tick == TICK_LAST) begin
                        tick  <= '0;
                        shreg <= {rxs, shreg[DBit-1:1]};
                        if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            n <= n + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: if (tick == TICK_LAST) begin
                        par_bit <= rxs;
                        tick    <= '0;
                        state   <= STOP;
                    end else begin
                        tick <= tick + 1'b1;
                    end
`endif
                    STOP: if (tick == STOP_LAST) begin
                        state        <= IDLE;
                        rx_dataOut   <= shreg;
                        rx_frame_err <= ~rxs;
                        rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        rx_parity_err <= (^shreg) ^ par_bit ^ rx_parity_odd;
`endif
                    end else begin
                        tick <= tick + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: s_tick every 4 PCLK, 64 PCLK per bit.
// Define UART_RX_PARITY_EN to also exercise the parity build.
module tb_uart_rx;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx_dataIn = 1'b1;
    logic       tick_en = 1'b1;
    logic [7:0] rx_dataOut;
    logic       rx_done_tick;
    logic       rx_frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_odd = 1'b0;
    logic       rx_parity_err;
`endif

    int total = 0;
    int bad = 0;
    int pulses = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];

    uart_rx dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .s_tick       (s_tick),
        .rx_dataIn    (rx_dataIn),
`ifdef UART_RX_PARITY_EN
        .rx_parity_odd(rx_parity_odd),
        .rx_parity_err(rx_parity_err),
`endif
        .rx_dataOut   (rx_dataOut),
        .rx_done_tick (rx_done_tick),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 PCLK = ~PCLK;

    initial begin : tickgen
        forever begin
            repeat (3) @(posedge PCLK);
            #1 s_tick = tick_en;
            @(posedge PCLK);
            #1 s_tick = 1'b0;
        end
    end

    // Advance n PCLK cycles; every done pulse is popped against the scoreboard.
    task automatic step(input int n);
        exp_t e;
        exp_t g;
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
            if (rx_done_tick === 1'b1) begin
                pulses++;
                total++;
                g.d  = rx_dataOut;
                g.fe = rx_frame_err;
`ifdef UART_RX_PARITY_EN
                g.pe = rx_parity_err;
`else
                g.pe = 1'b0;
`endif
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done got d=%h fe=%b pe=%b required none", g.d, g.fe, g.pe);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        bad++;
                        $display("FAIL frame got d=%h fe=%b pe=%b required d=%h fe=%b pe=%b",
                                 g.d, g.fe, g.pe, e.d, e.fe, e.pe);
                    end
                end
            end
        end
    endtask

    task automatic send_bit(input logic b);
        rx_dataIn = b;
        step(64);
    endtask

    // A low stop bit is released early so the idle FSM rejects its tail as a glitch.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
        exp_t e;
        e.d  = d;
        e.fe = ~stop;
        e.pe = pflip;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ rx_parity_odd ^ pflip);
`endif
        if (stop) begin
            send_bit(1'b1);
        end else begin
            rx_dataIn = 1'b0;
            step(40);
            rx_dataIn = 1'b1;
            step(24);
        end
    endtask

    task automatic check_idle(input string name, input int exp_pulses);
        total++;
        if (pulses !== exp_pulses) begin
            bad++;
            $display("FAIL %s_pulses got=%0d required=%0d", name, pulses, exp_pulses);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d required=0", name, exp_q.size());
        end
        total++;
        if (rx_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy got=%b required=0", name, rx_busy);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        step(5);
        total += 4;
        if (rx_dataOut !== 8'h00) begin bad++; $display("FAIL rst_data got=%h required=00", rx_dataOut); end
        if (rx_done_tick !== 1'b0) begin bad++; $display("FAIL rst_done got=%b required=0", rx_done_tick); end
        if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b required=0", rx_frame_err); end
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", rx_busy); end
        PRESETn = 1'b1;
        send_bit(1'b1);
    endtask

    task automatic test_basic();
        int p0 = pulses;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_bit(1'b1);
        check_idle("basic", p0 + 1);
    endtask

    task automatic test_glitch();
        int p0 = pulses;
        rx_dataIn = 1'b0;
        step(20);
        rx_dataIn = 1'b1;
        step(128);
        check_idle("glitch", p0);
        total++;
        if (rx_dataOut !== 8'hA5) begin bad++; $display("FAIL glitch_data got=%h required=a5", rx_dataOut); end
    endtask

    task automatic test_frame_err();
        int p0 = pulses;
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bit(1'b1);
        total++;
        if (rx_frame_err !== 1'b1) begin bad++; $display("FAIL ferr_hold got=%b required=1", rx_frame_err); end
        send_frame(8'h00, 1'b1, 1'b0);
        send_bit(1'b1);
        check_idle("ferr", p0 + 2);
        total++;
        if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b required=0", rx_frame_err); end
    endtask

    task automatic test_break();
        int p0 = pulses;
        send_frame(8'h00, 1'b0, 1'b0);
        send_bit(1'b1);
        send_frame(8'h96, 1'b1, 1'b0);
        send_bit(1'b1);
        check_idle("break", p0 + 2);
    endtask

    task automatic test_back_to_back();
        int p0 = pulses;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_bit(1'b1);
        check_idle("b2b", p0 + 2);
    endtask

    task automatic test_reset_midframe();
        int p0 = pulses;
        logic [7:0] d;
        d = 8'h55;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_dataIn = d[4];
        step(32);
        PRESETn = 1'b0;
        rx_dataIn = 1'b1;
        step(3);
        total += 2;
        if (rx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b required=0", rx_busy); end
        if (rx_dataOut !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h required=00", rx_dataOut); end
        PRESETn = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h81, 1'b1, 1'b0);
        send_bit(1'b1);
        check_idle("midrst", p0 + 1);
    endtask

    task automatic test_freeze();
        int p0 = pulses;
        logic [7:0] d;
        exp_t e;
        d = 8'h5A;
        e.d = d; e.fe = 1'b0; e.pe = 1'b0;
        exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 2; i++) send_bit(d[i]);
        rx_dataIn = d[2];
        step(32);
        tick_en = 1'b0;
        step(400);
        total += 2;
        if (rx_busy !== 1'b1) begin bad++; $display("FAIL freeze_busy got=%b required=1", rx_busy); end
        if (pulses !== p0) begin bad++; $display("FAIL freeze_pulses got=%0d required=%0d", pulses, p0); end
        tick_en = 1'b1;
        step(32);
        for (int i = 3; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ rx_parity_odd);
`endif
        send_bit(1'b1);
        send_bit(1'b1);
        check_idle("freeze", p0 + 1);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0 = pulses;
        rx_parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0);
        send_bit(1'b1);
        total++;
        if (rx_parity_err !== 1'b0) begin bad++; $display("FAIL par_ok got=%b required=0", rx_parity_err); end
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
        total++;
        if (rx_parity_err !== 1'b1) begin bad++; $display("FAIL par_bad got=%b required=1", rx_parity_err); end
        check_idle("parity", p0 + 2);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_break();
        test_back_to_back();
        test_reset_midframe();
        test_freeze();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
